oh_memory_ram_pipe: RTL
=======================

OH_MEMORY_RAM_PIPE -- requirements
Module: oh_memory_ram_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DW SHALL default to 104 and set the memory word width in bits.
REQ-003 Parameter DEPTH SHALL default to 32 and set the word count; it need not be a power of two.
REQ-004 Parameter AW SHALL default to $clog2(DEPTH) and set the address width.
REQ-005 Parameter RD_LAT SHALL default to 1 and set the read latency in cycles; legal values are 1..4.
REQ-006 Parameter RDW_MODE SHALL default to 0; 0 returns old data and 1 returns new data on a same-address read/write.
REQ-007 Port clk: input, 1 bit, the only clock.
REQ-008 Port rst: input, 1 bit, synchronous active-high reset.
REQ-009 Port rd_en: input, 1 bit, read request.
REQ-010 Port rd_addr: input, AW bits, read address.
REQ-011 Port rd_dout: output, DW bits, read data.
REQ-012 Port rd_valid: output, 1 bit, rd_dout carries the result of a read.
REQ-013 Port wr_en: input, 1 bit, write request.
REQ-014 Port wr_addr: input, AW bits, write address.
REQ-015 Port wr_wem: input, DW bits, per-bit write enable.
REQ-016 Port wr_din: input, DW bits, write data.
REQ-017 Port busy: output, 1 bit, initialisation in progress.

Function
REQ-018 A write SHALL update ram[wr_addr] bit i with wr_din[i] on the clk edge where wr_en=1 and wr_wem[i]=1; other bits are unchanged.
REQ-019 An accepted rd_en at edge t SHALL present the data and rd_valid=1 for exactly one cycle after edge t+RD_LAT-1, i.e. valid RD_LAT cycles after request.
REQ-020 Back-to-back reads SHALL be fully pipelined: one result per cycle, in request order.
REQ-021 rd_dout SHALL hold its last valid value while rd_valid=0.
REQ-022 On a same-cycle read and write to the same address, RDW_MODE=0 SHALL return the pre-write word.
REQ-023 On a same-cycle read and write to the same address, RDW_MODE=1 SHALL return the merged word: wr_din where wr_wem=1, old data elsewhere.
REQ-024 Writes to addresses >= DEPTH SHALL be dropped.
REQ-025 Reads from addresses >= DEPTH SHALL return all-zero data with rd_valid asserted normally.
REQ-026 While busy=1, rd_en and wr_en SHALL be ignored and no rd_valid SHALL be generated from them.

Reset
REQ-027 While rst=1, rd_valid SHALL be 0, rd_dout SHALL be 0 and every read pipeline stage SHALL be cleared.
REQ-028 Reads in flight when rst asserts SHALL be discarded and never produce rd_valid.
REQ-029 Memory contents SHALL NOT be reset directly; they are only cleared by the init engine (REQ-030).

Configuration
REQ-030 With OH_MEMORY_INIT_EN defined, the init engine SHALL behave as follows:
- It is a two-state FSM, IDLE and CLEAR; rst forces CLEAR with the address counter at 0.
- In CLEAR it writes zero to one address per cycle, 0..DEPTH-1, with busy=1.
- After writing DEPTH-1 it moves to IDLE and busy=0.
- Total busy time after rst deasserts is exactly DEPTH cycles.
- Reset asserted mid-clear restarts the clear at address 0.
REQ-031 Without OH_MEMORY_INIT_EN, the block SHALL have no FSM, busy SHALL be tied to 0, and memory SHALL power up undefined.

Structure
REQ-032 Shared package oh_memory_pkg SHALL hold the RDW_OLD=0 and RDW_NEW=1 constants and the init-state enum type (IDLE, CLEAR).
REQ-033 Sub-module oh_memory_rdpipe SHALL implement the RD_LAT-deep data/valid delay line with reset and hold behaviour.

Verification
REQ-034 Init: with the macro defined, DEPTH=32, and rst released at cycle 0 -> busy=1 for cycles 0..31 and 0 at cycle 32; every address reads 0.
REQ-035 Latency: RD_LAT=3, write 0xA5 to address 5, read address 5 at cycle t -> rd_valid=1 with rd_dout=0xA5 at t+3 only; four back-to-back reads of addresses 1..4 -> four consecutive valid cycles, in order.
REQ-036 Byte mask: word 0xFFFF, write wr_din=0x0000 with wr_wem=0x00FF -> read returns 0xFF00.
REQ-037 Read-during-write: address 7 holds 0x11, write 0x22 and read 7 in the same cycle -> RDW_MODE=0 returns 0x11 and RDW_MODE=1 returns 0x22.
REQ-038 Boundaries: DEPTH=20 and a write to address 25 -> no memory change and a read of 25 returns 0; rst pulsed at clear address 10 -> clear restarts at 0 and busy lasts 20 further cycles; rst with two reads in flight -> no rd_valid.

Source files
------------

// File: rtl/oh_memory_pkg.sv
// Shared constants and types for the oh_memory RAM family: read-during-write
// mode selectors and the init-engine state encoding.
package oh_memory_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } init_state_t;

endpackage

// File: rtl/oh_memory_rdpipe.sv
// RD_LAT-deep read result delay line; each data stage only loads when the
// stage ahead of it is valid, so the output holds the last valid word.
module oh_memory_rdpipe #(
  parameter int DW     = 104,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  output logic [DW-1:0] out_dat
);

  logic [RD_LAT-1:0] vld_p;
  logic [DW-1:0]     dat_p [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      for (int k = 0; k < RD_LAT; k++) dat_p[k] <= '0;
    end else begin
      // stage 0 captures the RAM read; later stages shift behind it
      vld_p[0] <= in_vld;
      if (in_vld) dat_p[0] <= in_dat;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        if (vld_p[k-1]) dat_p[k] <= dat_p[k-1];
      end
    end
  end

  assign out_vld = vld_p[RD_LAT-1];
  assign out_dat = dat_p[RD_LAT-1];

endmodule

// File: rtl/oh_memory_ram_pipe.sv
// Single-clock RAM with bit-masked writes and a pipelined read port.
// Define OH_MEMORY_INIT_EN to add the zero-fill init engine driving busy.
module oh_memory_ram_pipe
  import oh_memory_pkg::*;
#(
  parameter int DW       = 104,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dout,
  output logic          rd_valid,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_wem,
  input  logic [DW-1:0] wr_din,
  output logic          busy
);

  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  function automatic logic [DW-1:0] merge_word(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] din,
                                               input logic [DW-1:0] wem);
    return (old_w & ~wem) | (din & wem);
  endfunction

  logic [DW-1:0] ram [DEPTH];
  logic          rd_acc, wr_acc, rd_inr, wr_inr;
  logic [DW-1:0] rd_word, rd_data;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

`ifdef OH_MEMORY_INIT_EN
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  init_state_t   state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      if (clr_addr_q == LAST_ADDR) state_d = IDLE;
      else clr_addr_d = clr_addr_q + 1'b1;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy & ~rst;
  assign clr_addr = clr_addr_q;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign rd_inr = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_inr = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_acc = rd_en & ~busy & ~rst;
  assign wr_acc = wr_en & ~busy & ~rst & wr_inr;

  // out-of-range reads still return a (zero) result; RDW_NEW forwards the write
  assign rd_word = rd_inr ? ram[rd_addr] : '0;
  assign rd_data = (RDW_MODE == RDW_NEW && wr_acc && wr_addr == rd_addr)
                 ? merge_word(rd_word, wr_din, wr_wem) : rd_word;

  always_ff @(posedge clk) begin
    if (clr_we) ram[clr_addr] <= '0;
    else if (wr_acc) ram[wr_addr] <= merge_word(ram[wr_addr], wr_din, wr_wem);
  end

  oh_memory_rdpipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_acc),
    .in_dat  (rd_data),
    .out_vld (rd_valid),
    .out_dat (rd_dout)
  );

endmodule
